// File: rtl/ahb_interconnect_n.sv
// AHB-Lite single-master interconnect: region decoder, registered data-phase response mux and
// built-in default slave that answers unmapped transfers. Optional error counter: AHB_IC_ERRCNT_EN.
module ahb_interconnect_n #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int REGION_LSB = 28
) (
  input  logic                         clk,
  input  logic                         hreset,
  input  logic [ADDR_W-1:0]            haddr,
  input  logic [1:0]                   htrans,
  output logic [NUM_SLAVES-1:0]        hsel_s,
  output logic                         hready,
  output logic                         hresp,
  output logic [DATA_W-1:0]            hrdata,
  input  logic [NUM_SLAVES-1:0]        hreadyout_s,
  input  logic [NUM_SLAVES-1:0]        hresp_s,
  input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s
`ifdef AHB_IC_ERRCNT_EN
  ,
  output logic [15:0]                  err_count
`endif
);

  localparam int IDX_W = ADDR_W - REGION_LSB;
  localparam int TGT_W = $clog2(NUM_SLAVES + 1);
  localparam logic [TGT_W-1:0] DFLT = TGT_W'(NUM_SLAVES);

  typedef enum logic [1:0] {D_OK, D_ERR1, D_ERR2} dstate_e;

  logic [IDX_W-1:0] idx;
  logic [TGT_W-1:0] tgt;
  logic [TGT_W-1:0] dsel_d, dsel_q;
  logic             accept;
  dstate_e          dstate_q;
  logic             dflt_ready_q, dflt_resp_q;
  logic             unused_bits;

  assign idx         = haddr[ADDR_W-1:REGION_LSB];
  assign unused_bits = ^{haddr[REGION_LSB-1:0], htrans[0]};

  // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
  always_comb begin
    hsel_s = '0;
    tgt    = DFLT;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(idx) == i) begin
        hsel_s[i] = 1'b1;
        tgt       = TGT_W'(i);
      end
    end
  end

  // The data-phase owner only advances when the current data phase completes.
  assign dsel_d = hready ? tgt : dsel_q;

  always_comb begin
    hready = dflt_ready_q;
    hresp  = dflt_resp_q;
    hrdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q == TGT_W'(i)) begin
        hready = hreadyout_s[i];
        hresp  = hresp_s[i];
        hrdata = hrdata_s[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept = hready && htrans[1] && (tgt == DFLT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (hreset) dsel_q <= DFLT;
    else        dsel_q <= dsel_d;
  end

  // Default slave: Moore FSM, outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (hreset) begin
      dstate_q     <= D_OK;
      dflt_ready_q <= 1'b1;
      dflt_resp_q  <= 1'b0;
    end else begin
      case (dstate_q)
        D_OK: begin
          if (accept) begin
            dstate_q     <= D_ERR1;
            dflt_ready_q <= 1'b0;
            dflt_resp_q  <= 1'b1;
          end
        end
        D_ERR1: begin
          dstate_q     <= D_ERR2;
          dflt_ready_q <= 1'b1;
          dflt_resp_q  <= 1'b1;
        end
        D_ERR2: begin
          if (accept) begin
            dstate_q     <= D_ERR1;
            dflt_ready_q <= 1'b0;
            dflt_resp_q  <= 1'b1;
          end else begin
            dstate_q     <= D_OK;
            dflt_ready_q <= 1'b1;
            dflt_resp_q  <= 1'b0;
          end
        end
        default: begin
          dstate_q     <= D_OK;
          dflt_ready_q <= 1'b1;
          dflt_resp_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AHB_IC_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (hreset) begin
      err_cnt_q <= '0;
    end else if (accept && (dstate_q != D_ERR1) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ahb_interconnect_n.sv
// Directed bench for ahb_interconnect_n (4 slaves, 32-bit), expectations hand-derived per cycle.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_ahb_interconnect_n;

  localparam int NS = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              hreset;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic [NS-1:0]     hsel_s;
  logic              hready;
  logic              hresp;
  logic [DW-1:0]     hrdata;
  logic [NS-1:0]     hreadyout_s;
  logic [NS-1:0]     hresp_s;
  logic [NS*DW-1:0]  hrdata_s;
`ifdef AHB_IC_ERRCNT_EN
  logic [15:0]       err_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

  ahb_interconnect_n #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(DW), .REGION_LSB(28)) dut (
    .clk         (clk),
    .hreset      (hreset),
    .haddr       (haddr),
    .htrans      (htrans),
    .hsel_s      (hsel_s),
    .hready      (hready),
    .hresp       (hresp),
    .hrdata      (hrdata),
    .hreadyout_s (hreadyout_s),
    .hresp_s     (hresp_s),
    .hrdata_s    (hrdata_s)
`ifdef AHB_IC_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock, then leave one unit for inputs to be driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t);
    haddr  = a;
    htrans = t;
    #1;
  endtask

  task automatic check_errcnt(input string tag, input logic [15:0] exp);
`ifdef AHB_IC_ERRCNT_EN
    check(tag, {16'h0, err_count}, {16'h0, exp});
`endif
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    step();
    hreset = 1'b0;
  endtask

  initial begin
    hreset      = 1'b1;
    haddr       = 32'h0;
    htrans      = IDLE;
    hreadyout_s = 4'b1111;
    hresp_s     = 4'b0000;
    hrdata_s    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hA0A0_0000};

    // Reset then idle
    step();
    step();
    hreset = 1'b0;
    drive(32'h0000_0000, IDLE);
    check("rst_hready", {31'h0, hready}, 32'd1);
    check("rst_hresp",  {31'h0, hresp},  32'd0);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_hsel",   {28'h0, hsel_s}, 32'h1);
    check_errcnt("rst_errcnt", 16'd0);

    // Mapped read to slave 2 with two wait states
    step();
    drive(32'h2000_0010, NONSEQ);
    check("s2_hsel", {28'h0, hsel_s}, 32'h4);
    step();
    hreadyout_s[2] = 1'b0;
    drive(32'h0000_0000, NONSEQ);
    check("s2_wait1_hready", {31'h0, hready}, 32'd0);
    check("s2_wait1_hsel",   {28'h0, hsel_s}, 32'h1);
    step();
    drive(32'h0000_0000, NONSEQ);
    check("s2_wait2_hready", {31'h0, hready}, 32'd0);
    check("s2_wait2_hold",   hrdata, 32'h2222_2222);
    step();
    hreadyout_s[2]         = 1'b1;
    hrdata_s[2*DW +: DW]   = 32'hCAFE_F00D;
    drive(32'h0000_0000, NONSEQ);
    check("s2_done_hready", {31'h0, hready}, 32'd1);
    check("s2_done_hrdata", hrdata, 32'hCAFE_F00D);
    check("s2_done_hresp",  {31'h0, hresp},  32'd0);

    // Slave 0 data phase only now; next address is unmapped
    step();
    drive(32'h7000_0000, NONSEQ);
    check("s0_hrdata",    hrdata, 32'hA0A0_0000);
    check("unmap_hsel",   {28'h0, hsel_s}, 32'h0);
    step();
    drive(32'h7000_0000, IDLE);
    check("err1_hready", {31'h0, hready}, 32'd0);
    check("err1_hresp",  {31'h0, hresp},  32'd1);
    step();
    drive(32'h7000_0000, IDLE);
    check("err2_hready", {31'h0, hready}, 32'd1);
    check("err2_hresp",  {31'h0, hresp},  32'd1);
    check("err2_hrdata", hrdata, 32'h0);
    step();
    drive(32'h7000_0000, IDLE);
    check("after_err_hready", {31'h0, hready}, 32'd1);
    check("after_err_hresp",  {31'h0, hresp},  32'd0);
    check_errcnt("errcnt_one", 16'd1);
    step();
    drive(32'h7000_0000, IDLE);
    check("idle_unmap_hresp", {31'h0, hresp}, 32'd0);

    // Back-to-back unmapped transfers
    do_reset();
    drive(32'h5000_0000, NONSEQ);
    check("b2b_hsel", {28'h0, hsel_s}, 32'h0);
    step();
    drive(32'h5000_0004, SEQ);
    check("b2b_a_err1", {30'h0, hready, hresp}, 32'b01);
    step();
    drive(32'h5000_0004, SEQ);
    check("b2b_a_err2", {30'h0, hready, hresp}, 32'b11);
    step();
    drive(32'h1000_0000, IDLE);
    check("b2b_b_err1", {30'h0, hready, hresp}, 32'b01);
    step();
    drive(32'h1000_0000, IDLE);
    check("b2b_b_err2", {30'h0, hready, hresp}, 32'b11);
    step();
    check_errcnt("errcnt_two", 16'd2);

    // Pipelined: write slave 1, read slave 3, IDLE to unmapped
    drive(32'h1000_0000, NONSEQ);
    check("pipe_hsel1", {28'h0, hsel_s}, 32'h2);
    step();
    drive(32'h3000_0004, NONSEQ);
    check("pipe_hsel3", {28'h0, hsel_s}, 32'h8);
    check("pipe_s1_rd", hrdata, 32'h1111_1111);
    check("pipe_s1_rs", {30'h0, hready, hresp}, 32'b10);
    step();
    hresp_s[3] = 1'b1;
    drive(32'hF000_0000, IDLE);
    check("pipe_hsel_none", {28'h0, hsel_s}, 32'h0);
    check("pipe_s3_rd",     hrdata, 32'h3333_3333);
    check("pipe_s3_errpass", {31'h0, hresp}, 32'd1);
    step();
    hresp_s[3] = 1'b0;
    drive(32'hF000_0000, IDLE);
    check("pipe_dflt_rs", {30'h0, hready, hresp}, 32'b10);
    check("pipe_dflt_rd", hrdata, 32'h0);

    // Reset during D_ERR1
    drive(32'h7000_0000, NONSEQ);
    step();
    drive(32'h7000_0000, IDLE);
    check("rerr_err1", {30'h0, hready, hresp}, 32'b01);
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    drive(32'h7000_0000, IDLE);
    check("rerr_rs",     {30'h0, hready, hresp}, 32'b10);
    check("rerr_hrdata", hrdata, 32'h0);
    check_errcnt("rerr_errcnt", 16'd0);
    step();
    drive(32'h7000_0000, IDLE);
    check("rerr_stay_ok", {30'h0, hready, hresp}, 32'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
